// File: rtl/io_pkg.sv
// Shared definitions for the I/O register bank: register offsets, KEY_STATUS
// bit positions and the count-saturation helper.
package io_pkg;

    localparam logic [1:0] IO_MS_COUNT   = 2'd0;
    localparam logic [1:0] IO_KEY_DATA   = 2'd1;
    localparam logic [1:0] IO_KEY_STATUS = 2'd2;
    localparam logic [1:0] IO_RANDOM     = 2'd3;

    localparam int STAT_NOT_EMPTY = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_OVERFLOW  = 2;
    localparam int STAT_COUNT_LSB = 3;
    localparam int STAT_IRQ_EN    = 6;

    // The status register only has room for a 3-bit occupancy field.
    function automatic logic [2:0] satCount3(input int unsigned c);
        return (c > 7) ? 3'd7 : c[2:0];
    endfunction

endpackage

// File: rtl/io_key_fifo.sv
// Synchronous keyboard FIFO. A pop on an empty FIFO is a no-op; a push into a
// full FIFO is only accepted when a pop frees a slot in the same cycle.
module io_key_fifo #(
    parameter int DEPTH = 4,
    localparam int AW  = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    pushData,
    output logic [7:0]    head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic          doPush;
    logic          doPop;

    assign empty  = (count == '0);
    assign full   = (count == (AW+1)'(DEPTH));
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);
    assign head   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (doPop) begin
                rdPtr <= rdPtr + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_device_bank.sv
// Memory-mapped I/O bank: millisecond counter, keyboard FIFO with status/irq,
// and a Galois LFSR random source. Reads are combinational.
module io_device_bank
    import io_pkg::*;
#(
    parameter int          CLK_PER_MS = 50000,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] LFSR_POLY  = 32'h80200003
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [3:0]  addr,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    output logic        irq
);

    localparam int PW = $clog2(CLK_PER_MS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [PW-1:0] PRE_LAST = PW'(CLK_PER_MS - 1);

    logic [1:0]    regSel;
    logic          wrEn;
    logic          rdEn;
    logic          msWrite;
    logic          statusWrite;
    logic          lfsrWrite;
    logic          keyPop;
    logic          ovfSet;
    logic          unusedAddrBits;

    logic [PW-1:0] prescaler;
    logic [31:0]   msCount;
    logic [31:0]   lfsr;
    logic          overflow;
    logic          irqEn;
    logic [31:0]   statusWord;

    logic [7:0]    fifoHead;
    logic [AW:0]   fifoCount;
    logic          fifoFull;
    logic          fifoEmpty;

    assign regSel         = addr[3:2];
    assign unusedAddrBits = ^addr[1:0];

    // A simultaneous read+write strobe is treated as a write only: no pop.
    assign wrEn        = en && mem_write;
    assign rdEn        = en && mem_read && !mem_write;
    assign msWrite     = wrEn && (regSel == IO_MS_COUNT);
    assign statusWrite = wrEn && (regSel == IO_KEY_STATUS);
    assign lfsrWrite   = wrEn && (regSel == IO_RANDOM);
    assign keyPop      = rdEn && (regSel == IO_KEY_DATA);

    // key_valid is a fire-and-forget strobe with no ready: a code arriving at a
    // full FIFO with no same-cycle pop is dropped and latches overflow.
    assign ovfSet = key_valid && fifoFull && !keyPop;

    io_key_fifo #(.DEPTH(FIFO_DEPTH)) keyFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (key_valid),
        .pop      (keyPop),
        .pushData (key_code),
        .head     (fifoHead),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler <= '0;
            msCount   <= '0;
        end else if (msWrite) begin
            prescaler <= '0;
            msCount   <= '0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            msCount   <= msCount + 32'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            irqEn    <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (statusWrite) begin
                irqEn <= wdata[STAT_IRQ_EN];
            end
            // A drop in the same cycle as a clear must still be reported.
            if (ovfSet) begin
                overflow <= 1'b1;
            end else if (statusWrite && wdata[STAT_OVERFLOW]) begin
                overflow <= 1'b0;
            end
            irq <= irqEn && !fifoEmpty;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr <= 32'h1;
        end else if (lfsrWrite) begin
            lfsr <= (wdata == '0) ? 32'h1 : wdata;
        end else begin
            lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
        end
    end

    always_comb begin
        statusWord                          = '0;
        statusWord[STAT_NOT_EMPTY]          = !fifoEmpty;
        statusWord[STAT_FULL]               = fifoFull;
        statusWord[STAT_OVERFLOW]           = overflow;
        statusWord[STAT_COUNT_LSB +: 3]     = satCount3(32'(fifoCount));
        statusWord[STAT_IRQ_EN]             = irqEn;
    end

    always_comb begin
        rdata = '0;
        if (en && mem_read) begin
            case (regSel)
                IO_MS_COUNT:   rdata = msCount;
                IO_KEY_DATA:   rdata = {24'h0, fifoEmpty ? 8'h0 : fifoHead};
                IO_KEY_STATUS: rdata = statusWord;
                default:       rdata = lfsr;
            endcase
        end
    end

endmodule

// File: tb/tb_io_device_bank.sv
// Bench for io_device_bank: directed scenarios plus a random burst, checked by a
// queue-based scoreboard against a behavioural model of the register bank.
module tb_io_device_bank;
    import io_pkg::*;

    localparam int          CLK_PER_MS = 4;
    localparam int          DEPTH      = 4;
    localparam logic [31:0] POLY       = 32'h80200003;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  addr = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        key_valid = 1'b0;
    logic [7:0]  key_code = '0;
    logic        irq;
    logic        irqProbe = 1'b0;

    always #5 clk = ~clk;

    io_device_bank #(.CLK_PER_MS(CLK_PER_MS), .FIFO_DEPTH(DEPTH), .LFSR_POLY(POLY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .addr      (addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .wdata     (wdata),
        .rdata     (rdata),
        .key_valid (key_valid),
        .key_code  (key_code),
        .irq       (irq)
    );

    logic [31:0] exp_q[$];
    string       name_q[$];
    int          nCompared = 0;
    int          nMismatched = 0;

    // Behavioural model: elapsed cycles since clear, a byte queue for the FIFO.
    int          mCycles;
    byte unsigned mKeys[$];
    bit          mOvf;
    bit          mIrqEn;
    bit          mIrq;
    logic [31:0] mLfsr;

    function automatic logic [31:0] lfsrNext(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ POLY) : (v >> 1);
    endfunction

    function automatic logic [31:0] modelRead(input logic [1:0] sel);
        int c;
        logic [2:0] c3;
        c  = mKeys.size();
        c3 = 3'((c > 7) ? 7 : c);
        case (sel)
            2'd0:    return 32'(mCycles / CLK_PER_MS);
            2'd1:    return (c != 0) ? {24'h0, mKeys[0]} : 32'h0;
            2'd2:    return {25'h0, mIrqEn, c3, mOvf, (c == DEPTH), (c != 0)};
            default: return mLfsr;
        endcase
    endfunction

    function automatic void check(input logic [31:0] act);
        logic [31:0] e;
        string n;
        nCompared++;
        if (exp_q.size() == 0) begin
            nMismatched++;
            $display("FAIL unexpected_output: got %h, nothing expected", act);
        end else begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            if (act !== e) begin
                nMismatched++;
                $display("FAIL %s: got %h required %h", n, act, e);
            end
        end
    endfunction

    // Monitor: a raised read strobe or irq probe means the DUT is presenting output.
    always @(negedge clk) begin
        if (mem_read) check(rdata);
        if (irqProbe) check({31'b0, irq});
    end

    task automatic expectPush(input logic [31:0] v, input string nm);
        exp_q.push_back(v);
        name_q.push_back(nm);
    endtask

    task automatic cycle(input bit e, input bit rd, input bit wr, input logic [3:0] a,
                         input logic [31:0] wd, input bit kv, input logic [7:0] kc,
                         input string nm);
        bit wrEff, popReq, wasFull, nextIrq;
        en = e; mem_read = rd; mem_write = wr; addr = a; wdata = wd;
        key_valid = kv; key_code = kc;
        if (rd) expectPush(e ? modelRead(a[3:2]) : 32'h0, nm);
        if (irqProbe) expectPush({31'b0, mIrq}, "irq");

        wrEff   = e && wr;
        popReq  = e && rd && !wr && (a[3:2] == IO_KEY_DATA);
        wasFull = (mKeys.size() == DEPTH);
        nextIrq = mIrqEn && (mKeys.size() != 0);
        if (wrEff && a[3:2] == IO_KEY_STATUS) begin
            mIrqEn = wd[6];
            if (wd[2]) mOvf = 1'b0;
        end
        if (popReq && mKeys.size() != 0) void'(mKeys.pop_front());
        if (kv) begin
            if (!wasFull || popReq) mKeys.push_back(kc);
            else mOvf = 1'b1;
        end
        if (wrEff && a[3:2] == IO_MS_COUNT) mCycles = 0;
        else mCycles++;
        if (wrEff && a[3:2] == IO_RANDOM) mLfsr = (wd == 0) ? 32'h1 : wd;
        else mLfsr = lfsrNext(mLfsr);
        mIrq = nextIrq;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 4'h0, 32'h0, 0, 8'h0, "idle");
    endtask

    task automatic rdReg(input logic [1:0] r, input string nm);
        cycle(1, 1, 0, {r, 2'b00}, 32'h0, 0, 8'h0, nm);
    endtask

    task automatic wrReg(input logic [1:0] r, input logic [31:0] d);
        cycle(1, 0, 1, {r, 2'b00}, d, 0, 8'h0, "write");
    endtask

    task automatic pushKey(input logic [7:0] k);
        cycle(0, 0, 0, 4'h0, 32'h0, 1, k, "push");
    endtask

    task automatic doReset(input bit kv);
        rst_n = 1'b0; en = 1'b1; mem_read = 1'b0; mem_write = 1'b1;
        addr = 4'hC; wdata = 32'h1234; key_valid = kv; key_code = 8'hEE;
        if (irqProbe) expectPush({31'b0, mIrq}, "irq_pre_reset");
        mCycles = 0; mKeys.delete(); mOvf = 0; mIrqEn = 0; mIrq = 0; mLfsr = 32'h1;
        @(posedge clk);
        #1;
        rst_n = 1'b1; en = 1'b0; mem_write = 1'b0; key_valid = 1'b0;
    endtask

    initial begin
        int guard;
        doReset(0);
        rdReg(0, "rst_ms"); rdReg(1, "rst_key"); rdReg(2, "rst_status"); rdReg(3, "rst_random");

        doReset(0);
        idle(12);
        rdReg(0, "ms_after_12");
        doReset(0);
        idle(10);
        wrReg(0, 32'h0);
        rdReg(0, "ms_after_clear");
        idle(2);
        rdReg(0, "ms_clear_plus3");
        rdReg(0, "ms_clear_plus4");

        pushKey(8'h41); pushKey(8'h42);
        rdReg(2, "status_two"); rdReg(1, "key_first"); rdReg(1, "key_second");
        rdReg(2, "status_drained"); rdReg(1, "key_empty_read");

        for (int i = 0; i < 5; i++) pushKey(8'h50 + 8'(i));
        rdReg(2, "status_overflow"); rdReg(1, "key_after_ovf");
        wrReg(2, 32'h4);
        rdReg(2, "status_ovf_cleared");

        pushKey(8'h60);
        cycle(1, 1, 0, 4'h4, 32'h0, 1, 8'h61, "key_full_pushpop");
        rdReg(2, "status_full_pushpop");
        cycle(1, 1, 1, 4'h4, 32'h0, 0, 8'h0, "key_rdwr_no_pop");
        cycle(0, 1, 1, 4'h0, 32'h0, 0, 8'h0, "disabled_read");
        for (int i = 0; i < 4; i++) rdReg(1, "key_drain");
        rdReg(2, "status_empty");

        wrReg(3, 32'h0); rdReg(3, "rand_seed0"); rdReg(3, "rand_step");
        wrReg(3, 32'hDEADBEEF); rdReg(3, "rand_seed"); rdReg(3, "rand_seed_step");

        irqProbe = 1'b1;
        wrReg(2, 32'h40);
        pushKey(8'h70);
        idle(2);
        rdReg(1, "irq_pop");
        idle(2);
        pushKey(8'h71); pushKey(8'h72); wrReg(3, 32'h123);
        doReset(1);
        rdReg(0, "mid_rst_ms"); rdReg(1, "mid_rst_key"); rdReg(2, "mid_rst_status"); rdReg(3, "mid_rst_random");

        for (int i = 0; i < 400; i++) begin
            logic [31:0] wd;
            wd = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 99) == 0) doReset($urandom_range(0, 1) == 1);
            else cycle($urandom_range(0, 9) != 0, $urandom_range(0, 1) == 1,
                       $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)), wd,
                       $urandom_range(0, 2) == 0, 8'($urandom_range(0, 255)), "random");
        end

        irqProbe = 1'b0;
        idle(2);
        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            nCompared++;
            nMismatched++;
            $display("FAIL drain: %0d outputs never observed, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
